axi_burst_mem_slave: RTL and testbench

AXI4 memory-backed slave, the parametrised successor of the current AXI slave: full 8-bit burst length, FIXED/INCR/WRAP bursts, narrow transfers, byte strobes, and SLVERR on illegal or out-of-range access. It sits opposite `axi_master` in the AXI test environment and serves as the shared on-chip RAM target for later system benches. Read and write channels are independent FSMs sharing one word-addressed array.

---
 rtl/axi_burst_mem_slave.sv | 266 ++++++++++++++++++++++++++
 tb/tb_axi_burst_mem_slave.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_mem_slave.sv
`default_nettype none
// ============================================================================
// Module   : axi_burst_mem_slave
// Purpose  : AXI4 memory-backed slave. FIXED/INCR/WRAP bursts up to 256
//            beats, narrow transfers, byte strobes, SLVERR on illegal bursts
//            or out-of-range beats. Independent read and write FSMs share
//            one word-addressed array.
// Ports    : clk/rst            - clock, synchronous active-high reset
//            aw*/w*/b*          - write address, data and response channels
//            ar*/r*             - read address and data channels
// Revision : 1.0 - initial release
// ============================================================================
module axi_burst_mem_slave #(
    parameter int              ID_W        = 4,
    parameter int              AW          = 32,
    parameter int              DW          = 32,
    parameter int              DEPTH_WORDS = 1024,
    parameter logic [AW-1:0]   BASE_ADDR   = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                awvalid,
    output logic                awready,
    input  logic [AW-1:0]       awaddr,
    input  logic [7:0]          awlen,
    input  logic [2:0]          awsize,
    input  logic [1:0]          awburst,
    input  logic [ID_W-1:0]     awid,
    input  logic                wvalid,
    output logic                wready,
    input  logic [DW-1:0]       wdata,
    input  logic [DW/8-1:0]     wstrb,
    input  logic                wlast,
    output logic                bvalid,
    input  logic                bready,
    output logic [1:0]          bresp,
    output logic [ID_W-1:0]     bid,
    input  logic                arvalid,
    output logic                arready,
    input  logic [AW-1:0]       araddr,
    input  logic [7:0]          arlen,
    input  logic [2:0]          arsize,
    input  logic [1:0]          arburst,
    input  logic [ID_W-1:0]     arid,
    output logic                rvalid,
    input  logic                rready,
    output logic [DW-1:0]       rdata,
    output logic [1:0]          rresp,
    output logic                rlast,
    output logic [ID_W-1:0]     rid
);
    localparam int              c_NB       = DW / 8;
    localparam int              c_LG       = $clog2(c_NB);
    localparam int              c_IW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [2:0]      c_MAX_SIZE = 3'(c_LG);
    localparam logic [AW-1:0]   c_DEPTH    = AW'(DEPTH_WORDS);
    localparam logic [1:0]      c_OKAY     = 2'b00;
    localparam logic [1:0]      c_SLVERR   = 2'b10;
    localparam logic [1:0]      c_INCR     = 2'b01;
    localparam logic [1:0]      c_WRAP     = 2'b10;

    function automatic logic burst_bad(input logic [7:0] len, input logic [2:0] size,
                                       input logic [1:0] burst);
        logic wrap_len_ok;
        wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        return (size > c_MAX_SIZE) || (burst == 2'b11) || ((burst == c_WRAP) && !wrap_len_ok);
    endfunction

    // Borrow bit of the offset subtraction flags addresses below the base.
    function automatic logic in_range(input logic [AW-1:0] addr);
        logic [AW:0] diff;
        diff = {1'b0, addr} - {1'b0, BASE_ADDR};
        return !diff[AW] && ((diff[AW-1:0] >> c_LG) < c_DEPTH);
    endfunction

    function automatic logic [c_IW-1:0] word_idx(input logic [AW-1:0] addr);
        return c_IW'((addr - BASE_ADDR) >> c_LG);
    endfunction

    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] addr, input logic [7:0] len,
                                                 input logic [2:0] size, input logic [1:0] burst);
        logic [AW-1:0] bytes;
        logic [AW-1:0] span;
        logic [AW-1:0] nxt;
        bytes = AW'(1) << size;
        span  = bytes * (AW'(len) + AW'(1));
        if (burst == c_INCR)      nxt = addr + bytes;
        else if (burst == c_WRAP) nxt = (addr & ~(span - AW'(1))) | ((addr + bytes) & (span - AW'(1)));
        else                      nxt = addr;
        return nxt;
    endfunction

    logic [DW-1:0] mem [DEPTH_WORDS];

    // ------------------------------------------------------------------ write
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
    wr_state_t         wr_state_q, wr_state_d;
    logic [AW-1:0]     wr_addr_q, wr_addr_d;
    logic [7:0]        wr_len_q, wr_len_d, wr_cnt_q, wr_cnt_d;
    logic [2:0]        wr_size_q, wr_size_d;
    logic [1:0]        wr_burst_q, wr_burst_d;
    logic              wr_bad_q, wr_bad_d, wr_err_q, wr_err_d;
    logic              awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic [1:0]        bresp_q, bresp_d;
    logic [ID_W-1:0]   bid_q, bid_d;
    logic              mem_we, wr_beat_last, wr_beat_err;

    always_comb begin
        wr_state_d = wr_state_q;  wr_addr_d  = wr_addr_q;  wr_len_d  = wr_len_q;
        wr_cnt_d   = wr_cnt_q;    wr_size_d  = wr_size_q;  wr_burst_d = wr_burst_q;
        wr_bad_d   = wr_bad_q;    wr_err_d   = wr_err_q;   awready_d = awready_q;
        wready_d   = wready_q;    bvalid_d   = bvalid_q;   bresp_d   = bresp_q;
        bid_d      = bid_q;       mem_we     = 1'b0;
        wr_beat_last = (wr_cnt_q == wr_len_q);
        // A wlast that disagrees with the beat count only taints the response.
        wr_beat_err  = wr_bad_q || !in_range(wr_addr_q) || (wlast != wr_beat_last);
        case (wr_state_q)
            W_IDLE: begin
                awready_d = 1'b1;
                if (awvalid && awready_q) begin
                    wr_addr_d  = awaddr;  wr_len_d   = awlen;  wr_size_d = awsize;
                    wr_burst_d = awburst; bid_d      = awid;   wr_cnt_d  = 8'd0;
                    wr_bad_d   = burst_bad(awlen, awsize, awburst);
                    wr_err_d   = 1'b0;    awready_d  = 1'b0;   wready_d  = 1'b1;
                    wr_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (wvalid && wready_q) begin
                    mem_we   = !wr_bad_q && in_range(wr_addr_q);
                    wr_err_d = wr_err_q || wr_beat_err;
                    if (wr_beat_last) begin
                        wready_d   = 1'b0;
                        bvalid_d   = 1'b1;
                        bresp_d    = (wr_err_q || wr_beat_err) ? c_SLVERR : c_OKAY;
                        wr_state_d = W_RESP;
                    end else begin
                        wr_cnt_d  = wr_cnt_q + 8'd1;
                        wr_addr_d = next_addr(wr_addr_q, wr_len_q, wr_size_q, wr_burst_q);
                    end
                end
            end
            W_RESP: begin
                if (bready && bvalid_q) begin
                    bvalid_d   = 1'b0;
                    awready_d  = 1'b1;
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    // Memory has no reset; writes are blocked on the reset edge itself.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            for (int b = 0; b < c_NB; b++) begin
                if (wstrb[b]) mem[word_idx(wr_addr_q)][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // ------------------------------------------------------------------- read
    typedef enum logic [0:0] {R_IDLE, R_DATA} rd_state_t;
    rd_state_t         rd_state_q, rd_state_d;
    logic [AW-1:0]     rd_addr_q, rd_addr_d, rd_fetch_addr;
    logic [7:0]        rd_len_q, rd_len_d, rd_cnt_q, rd_cnt_d;
    logic [2:0]        rd_size_q, rd_size_d;
    logic [1:0]        rd_burst_q, rd_burst_d;
    logic              rd_bad_q, rd_bad_d, rd_fetch, rd_fetch_bad, ar_bad;
    logic              arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;
    logic [ID_W-1:0]   rid_q, rid_d;

    always_comb begin
        rd_state_d = rd_state_q;  rd_addr_d  = rd_addr_q;  rd_len_d   = rd_len_q;
        rd_cnt_d   = rd_cnt_q;    rd_size_d  = rd_size_q;  rd_burst_d = rd_burst_q;
        rd_bad_d   = rd_bad_q;    arready_d  = arready_q;  rvalid_d   = rvalid_q;
        rlast_d    = rlast_q;     rdata_d    = rdata_q;    rresp_d    = rresp_q;
        rid_d      = rid_q;       rd_fetch   = 1'b0;
        ar_bad        = burst_bad(arlen, arsize, arburst);
        rd_fetch_addr = next_addr(rd_addr_q, rd_len_q, rd_size_q, rd_burst_q);
        rd_fetch_bad  = rd_bad_q;
        case (rd_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (arvalid && arready_q) begin
                    rd_addr_d  = araddr;  rd_len_d  = arlen;  rd_size_d = arsize;
                    rd_burst_d = arburst; rd_bad_d  = ar_bad; rid_d     = arid;
                    rd_cnt_d   = 8'd0;    rlast_d   = (arlen == 8'd0);
                    rvalid_d   = 1'b1;    arready_d = 1'b0;
                    rd_fetch      = 1'b1;
                    rd_fetch_addr = araddr;
                    rd_fetch_bad  = ar_bad;
                    rd_state_d    = R_DATA;
                end
            end
            R_DATA: begin
                if (rready && rvalid_q) begin
                    if (rlast_q) begin
                        rvalid_d   = 1'b0;
                        rlast_d    = 1'b0;
                        arready_d  = 1'b1;
                        rd_state_d = R_IDLE;
                    end else begin
                        // Fetch the next beat on the handshake edge so beats stream back-to-back.
                        rd_fetch  = 1'b1;
                        rd_addr_d = rd_fetch_addr;
                        rd_cnt_d  = rd_cnt_q + 8'd1;
                        rlast_d   = ((rd_cnt_q + 8'd1) == rd_len_q);
                    end
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
        if (rd_fetch) begin
            if (!rd_fetch_bad && in_range(rd_fetch_addr)) begin
                rdata_d = mem[word_idx(rd_fetch_addr)];
                rresp_d = c_OKAY;
            end else begin
                rdata_d = '0;
                rresp_d = c_SLVERR;
            end
        end
    end

    // ------------------------------------------------------------- registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state_q <= W_IDLE;  wr_addr_q <= '0;    wr_len_q  <= '0;   wr_cnt_q <= '0;
            wr_size_q  <= '0;      wr_burst_q <= '0;   wr_bad_q  <= 1'b0; wr_err_q <= 1'b0;
            awready_q  <= 1'b0;    wready_q  <= 1'b0;  bvalid_q  <= 1'b0;
            bresp_q    <= '0;      bid_q     <= '0;
            rd_state_q <= R_IDLE;  rd_addr_q <= '0;    rd_len_q  <= '0;   rd_cnt_q <= '0;
            rd_size_q  <= '0;      rd_burst_q <= '0;   rd_bad_q  <= 1'b0;
            arready_q  <= 1'b0;    rvalid_q  <= 1'b0;  rlast_q   <= 1'b0;
            rdata_q    <= '0;      rresp_q   <= '0;    rid_q     <= '0;
        end else begin
            wr_state_q <= wr_state_d;  wr_addr_q <= wr_addr_d;   wr_len_q <= wr_len_d;
            wr_cnt_q   <= wr_cnt_d;    wr_size_q <= wr_size_d;   wr_burst_q <= wr_burst_d;
            wr_bad_q   <= wr_bad_d;    wr_err_q  <= wr_err_d;    awready_q <= awready_d;
            wready_q   <= wready_d;    bvalid_q  <= bvalid_d;    bresp_q  <= bresp_d;
            bid_q      <= bid_d;
            rd_state_q <= rd_state_d;  rd_addr_q <= rd_addr_d;   rd_len_q <= rd_len_d;
            rd_cnt_q   <= rd_cnt_d;    rd_size_q <= rd_size_d;   rd_burst_q <= rd_burst_d;
            rd_bad_q   <= rd_bad_d;    arready_q <= arready_d;   rvalid_q <= rvalid_d;
            rlast_q    <= rlast_d;     rdata_q   <= rdata_d;     rresp_q  <= rresp_d;
            rid_q      <= rid_d;
        end
    end

    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;
    assign bid     = bid_q;
    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign rlast   = rlast_q;
    assign rid     = rid_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_burst_mem_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_burst_mem_slave
// Purpose  : Self-checking bench for axi_burst_mem_slave (16-word memory).
//            A burst-level memory model predicts every R beat and B response;
//            a monitor compares them on each handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_burst_mem_slave;
    localparam int ID_W = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic arvalid, arready, rvalid, rready, rlast;
    logic [AW-1:0] awaddr, araddr;
    logic [7:0] awlen, arlen;
    logic [2:0] awsize, arsize;
    logic [1:0] awburst, arburst, bresp, rresp;
    logic [ID_W-1:0] awid, bid, arid, rid;
    logic [DW-1:0] wdata, rdata;
    logic [DW/8-1:0] wstrb;

    axi_burst_mem_slave #(.ID_W(ID_W), .AW(AW), .DW(DW), .DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .rst(rst),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awid(awid),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arid(arid),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rid(rid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------------------------------------------------------- model
    typedef struct { logic [31:0] data; logic [1:0] resp; logic last; logic [3:0] id; } rbeat_t;
    typedef struct { logic [1:0] resp; logic [3:0] id; } bexp_t;
    rbeat_t rq[$];
    rbeat_t cap[$];
    bexp_t  bq[$];
    logic [31:0] mdl_mem [DEPTH];
    logic [31:0] wdat [16];
    logic [3:0]  wstb [16];
    bit          rr_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    function automatic bit mdl_legal(int len, int size, int burst);
        if (size > 2 || burst == 3) return 1'b0;
        if (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15)) return 1'b0;
        return 1'b1;
    endfunction

    // Address of beat k, computed directly from the start address.
    function automatic int unsigned mdl_addr(int unsigned a, int len, int size, int burst, int k);
        int unsigned nb;
        int unsigned span;
        int unsigned base;
        nb   = 1 << size;
        span = nb * (len + 1);
        if (burst == 0) return a;
        if (burst == 1) return a + k * nb;
        base = a - (a % span);
        return base + ((a - base + k * nb) % span);
    endfunction

    function automatic bit mdl_in_range(int unsigned a);
        return a < DEPTH * 4;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------ write task
    task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [3:0] id, input int wlast_at,
                            input int bready_delay, input int abort_after);
        bit legal;
        bit err;
        int n;
        int unsigned a;
        bexp_t be;
        legal = mdl_legal(len, size, burst);
        err = !legal || (wlast_at != int'(len));
        for (int k = 0; k <= int'(len); k++)
            if (!mdl_in_range(mdl_addr(addr, len, size, burst, k))) err = 1'b1;
        if (abort_after < 0) begin
            be.resp = err ? 2'b10 : 2'b00;
            be.id = id;
            bq.push_back(be);
        end
        awvalid = 1'b1; awaddr = addr; awlen = len; awsize = size; awburst = burst; awid = id;
        n = 0;
        while (!awready && n < 50) begin tick(); n++; end
        chk("aw_ready", awready, 1);
        tick();
        awvalid = 1'b0;
        chk("aw_to_wready", wready, 1);
        for (int k = 0; k <= int'(len); k++) begin
            wvalid = 1'b1; wdata = wdat[k]; wstrb = wstb[k]; wlast = (k == wlast_at);
            n = 0;
            while (!wready && n < 50) begin tick(); n++; end
            chk("w_ready", wready, 1);
            tick();
            a = mdl_addr(addr, len, size, burst, k);
            if (legal && mdl_in_range(a))
                for (int b = 0; b < 4; b++)
                    if (wstb[k][b]) mdl_mem[a >> 2][8*b +: 8] = wdat[k][8*b +: 8];
            if (k == abort_after) begin
                wvalid = 1'b0; wlast = 1'b0; rst = 1'b1;
                tick();
                chk("rst_mid_write_outputs", {wready, bvalid, awready}, 3'b000);
                rst = 1'b0;
                tick();
                chk("rst_release_awready", awready, 1);
                return;
            end
        end
        wvalid = 1'b0; wlast = 1'b0;
        chk("last_w_to_bvalid", {wready, bvalid}, 2'b01);
        for (int i = 0; i < bready_delay; i++) begin
            chk("b_hold_no_awready", {bvalid, awready}, 2'b10);
            tick();
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        chk("b_to_awready", {bvalid, awready}, 2'b01);
        chk("b_drained", bq.size(), 0);
    endtask

    // ------------------------------------------------------------- read task
    task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] id, input bit toggle);
        bit legal;
        bit ok;
        int n;
        int unsigned a;
        rbeat_t e;
        legal = mdl_legal(len, size, burst);
        for (int k = 0; k <= int'(len); k++) begin
            a = mdl_addr(addr, len, size, burst, k);
            ok = legal && mdl_in_range(a);
            e.data = ok ? mdl_mem[a >> 2] : 32'h0;
            e.resp = ok ? 2'b00 : 2'b10;
            e.last = (k == int'(len));
            e.id = id;
            rq.push_back(e);
        end
        cap.delete();
        arvalid = 1'b1; araddr = addr; arlen = len; arsize = size; arburst = burst; arid = id;
        n = 0;
        while (!arready && n < 50) begin tick(); n++; end
        chk("ar_ready", arready, 1);
        tick();
        arvalid = 1'b0;
        chk("ar_to_rvalid", rvalid, 1);
        n = 0;
        while (rq.size() > 0 && n < 200) begin
            rready = toggle ? rr_pat[n % 4] : 1'b1;
            tick();
            n++;
        end
        rready = 1'b0;
        chk("r_drained", rq.size(), 0);
        chk("r_last_to_arready", {rvalid, arready}, 2'b01);
    endtask

    // -------------------------------------------------------------- monitor
    initial begin
        logic [39:0] snap;
        bit stalled;
        rbeat_t e;
        rbeat_t c;
        bexp_t be;
        stalled = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled = 1'b0;
            end else begin
                if (stalled) chk("r_stall_hold", {rvalid, rdata, rresp, rlast, rid}, snap);
                stalled = 1'b0;
                if (rvalid && !rready) begin
                    stalled = 1'b1;
                    snap = {rvalid, rdata, rresp, rlast, rid};
                end
                if (rvalid && rready) begin
                    if (rq.size() == 0) chk("r_unexpected_beat", rvalid, 0);
                    else begin
                        e = rq.pop_front();
                        chk("rdata", rdata, e.data);
                        chk("rresp", rresp, e.resp);
                        chk("rlast", rlast, e.last);
                        chk("rid", rid, e.id);
                        c.data = rdata; c.resp = rresp; c.last = rlast; c.id = rid;
                        cap.push_back(c);
                    end
                end
                if (bvalid && bready) begin
                    if (bq.size() == 0) chk("b_unexpected", bvalid, 0);
                    else begin
                        be = bq.pop_front();
                        chk("bresp", bresp, be.resp);
                        chk("bid", bid, be.id);
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, got timeout expected completion");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // ------------------------------------------------------------- stimulus
    initial begin
        awvalid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0; awid = 0;
        wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
        arvalid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; arid = 0; rready = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {awready, wready, bvalid, arready, rvalid, rlast,
                              bresp, rresp, bid, rid, rdata}, 64'h0);
        rst = 1'b0;
        tick();
        chk("post_reset_ready", {awready, arready}, 2'b11);

        // Fill the whole memory with a known pattern.
        for (int k = 0; k < 16; k++) begin wdat[k] = 32'h1000_0000 + k; wstb[k] = 4'hF; end
        do_write(32'h0, 8'd15, 3'd2, 2'd1, 4'h1, 15, 0, -1);

        // INCR write and read-back.
        for (int k = 0; k < 4; k++) wdat[k] = 32'hA0 + k;
        do_write(32'h10, 8'd3, 3'd2, 2'd1, 4'h5, 3, 0, -1);
        do_read(32'h10, 8'd3, 3'd2, 2'd1, 4'h9, 1'b0);
        chk("incr_b0", cap[0].data, 32'hA0);
        chk("incr_b3", cap[3].data, 32'hA3);
        chk("incr_rlast_pattern", {cap[3].last, cap[2].last, cap[1].last, cap[0].last}, 4'b1000);
        chk("incr_rid", cap[0].id, 4'h9);

        // WRAP read order 0x18,0x1C,0x10,0x14.
        do_read(32'h18, 8'd3, 3'd2, 2'd2, 4'h2, 1'b0);
        chk("wrap_order", {cap[0].data[7:0], cap[1].data[7:0], cap[2].data[7:0], cap[3].data[7:0]},
            32'hA2A3A0A1);

        // Illegal WRAP length: three SLVERR beats with zero data.
        do_read(32'h18, 8'd2, 3'd2, 2'd2, 4'h3, 1'b0);
        chk("wrap_len2_beats", cap.size(), 3);
        for (int k = 0; k < 3; k++) chk("wrap_len2_slverr", {cap[k].resp, cap[k].data}, {2'b10, 32'h0});

        // FIXED burst with rotating byte strobes.
        for (int k = 0; k < 4; k++) begin wdat[k] = 32'h1111_1111 * (k + 1); wstb[k] = 4'b0001 << k; end
        do_write(32'h30, 8'd3, 3'd2, 2'd0, 4'h3, 3, 0, -1);
        do_read(32'h30, 8'd0, 3'd2, 2'd1, 4'h3, 1'b0);
        chk("fixed_strobe_word", cap[0].data, 32'h4433_2211);

        // FIXED write entirely past the end of a 16-word memory.
        do_write(32'h40, 8'd3, 3'd2, 2'd0, 4'h4, 3, 0, -1);

        // INCR straddling the end of memory.
        for (int k = 0; k < 4; k++) begin wdat[k] = 32'hB0 + k; wstb[k] = 4'hF; end
        do_write(32'h38, 8'd3, 3'd2, 2'd1, 4'h6, 3, 0, -1);
        do_read(32'h38, 8'd3, 3'd2, 2'd1, 4'h6, 1'b0);
        chk("oor_rresp", {cap[0].resp, cap[1].resp, cap[2].resp, cap[3].resp}, 8'b00_00_10_10);
        chk("oor_rdata_lo", {cap[0].data, cap[1].data}, {32'hB0, 32'hB1});
        chk("oor_rdata_hi", {cap[2].data, cap[3].data}, 64'h0);

        // Early wlast taints bresp; bready held low for 5 cycles.
        wdat[0] = 32'hC0; wdat[1] = 32'hC1;
        do_write(32'h20, 8'd1, 3'd2, 2'd1, 4'h7, 0, 5, -1);

        // Oversized beat is illegal: nothing written.
        wdat[0] = 32'hDEAD_BEEF;
        do_write(32'h0, 8'd0, 3'd3, 2'd1, 4'h8, 0, 0, -1);

        // Length-8 read with rready 1,0,0,1 backpressure.
        do_read(32'h0, 8'd7, 3'd2, 2'd1, 4'hA, 1'b1);
        chk("bp_word0", cap[0].data, 32'h1000_0000);
        chk("bp_word4", cap[4].data, 32'hA0);

        // Reset during a write after beat 1.
        for (int k = 0; k < 4; k++) begin wdat[k] = 32'hE0 + k; wstb[k] = 4'hF; end
        do_write(32'h0, 8'd3, 3'd2, 2'd1, 4'h9, 3, 0, 1);
        do_read(32'h0, 8'd3, 3'd2, 2'd1, 4'h1, 1'b0);
        chk("rst_partial_words", {cap[0].data, cap[1].data}, {32'hE0, 32'hE1});
        chk("rst_untouched_words", {cap[2].data, cap[3].data}, {32'h1000_0002, 32'h1000_0003});

        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
